mu_skid_buffer: RTL and testbench

Two-entry ready/valid skid buffer for the memory-unit pipeline. It sits directly upstream of the memory unit's bit-level state registers and decouples the execute stage from memory-unit back-pressure without a combinational ready path. It sustains one beat per cycle, has one cycle of forward latency, and preserves order.

---
 rtl/mu_pkg.sv | 12 +
 rtl/mu_skid_buffer_if.sv | 33 +++
 rtl/mu_sb_reg.sv | 20 ++
 rtl/mu_skid_buffer.sv | 99 +++++++++
 tb/tb_mu_skid_buffer.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/mu_pkg.sv
// Shared types and constants for the memory-unit skid buffer.
package mu_pkg;

  typedef enum logic [1:0] {
    MU_SB_EMPTY = 2'd0,
    MU_SB_BUSY  = 2'd1,
    MU_SB_FULL  = 2'd2
  } mu_sb_state_e;

  localparam int MU_SB_DEPTH = 2;

endpackage

// File: rtl/mu_skid_buffer_if.sv
// Ready/valid bus around mu_skid_buffer; the flush wire exists only when MU_SKID_FLUSH_EN is defined.
interface mu_skid_buffer_if import mu_pkg::*; #(
  parameter int WIDTH = 32
) ();

  logic                                 in_valid;
  logic                                 in_ready;
  logic [WIDTH-1:0]                     in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [WIDTH-1:0]                     out_data;
  logic [$clog2(MU_SB_DEPTH+1)-1:0]     occ;
`ifdef MU_SKID_FLUSH_EN
  logic                                 flush;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef MU_SKID_FLUSH_EN
    output flush,
`endif
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef MU_SKID_FLUSH_EN
    input  flush,
`endif
    output in_ready, out_valid, out_data, occ
  );

endinterface

// File: rtl/mu_sb_reg.sv
// WIDTH-bit load-enabled register with synchronous active-high clear; bus form of the state flop.
module mu_sb_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mu_skid_buffer.sv
// Two-entry ready/valid skid buffer: registered in_ready, one-cycle latency, in-order.
// Optional synchronous flush input enabled by defining MU_SKID_FLUSH_EN.
module mu_skid_buffer import mu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mu_skid_buffer_if.slave   bus
);

  mu_sb_state_e     state;
  mu_sb_state_e     state_next;
  logic             accept;
  logic             pop;
  logic             load_main;
  logic             load_skid;
  logic             flush_now;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

`ifdef MU_SKID_FLUSH_EN
  assign flush_now = bus.flush;
`else
  assign flush_now = 1'b0;
`endif

  // in_ready is a pure function of registered state, never of out_ready
  assign bus.in_ready  = !reset && (state != MU_SB_FULL) && !flush_now;
  assign bus.out_valid = (state != MU_SB_EMPTY);
  assign bus.out_data  = main_q;
  assign bus.occ       = state;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;
  assign main_d = (state == MU_SB_FULL) ? skid_q : bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MU_SB_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    case (state)
      MU_SB_EMPTY: begin
        if (accept) begin
          state_next = MU_SB_BUSY;
          load_main  = 1'b1;
        end
      end
      MU_SB_BUSY: begin
        if (accept && !pop) begin
          state_next = MU_SB_FULL;
          load_skid  = 1'b1;
        end else if (pop && !accept) begin
          state_next = MU_SB_EMPTY;
        end else if (accept && pop) begin
          load_main  = 1'b1;
        end
      end
      MU_SB_FULL: begin
        if (pop) begin
          state_next = MU_SB_BUSY;
          load_main  = 1'b1;
        end
      end
      default: state_next = MU_SB_EMPTY;
    endcase
    // Flush invalidates entries but leaves the data registers untouched
    if (flush_now) begin
      state_next = MU_SB_EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
    end
  end

  mu_sb_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  mu_sb_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (bus.in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_mu_skid_buffer.sv
// Directed bench for mu_skid_buffer with an in-order scoreboard and occupancy model.
module tb_mu_skid_buffer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mu_skid_buffer_if #(.WIDTH(W)) bus ();

  mu_skid_buffer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int            tests = 0;
  int            fails = 0;
  int            m_occ = 0;
  bit            known = 1'b0;
  logic [W-1:0]  sb[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check against the model, update model, wait for posedge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [W-1:0] id, input logic ordy);
    logic exp_ready;
    logic do_pop;
    logic do_acc;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
`ifdef MU_SKID_FLUSH_EN
    bus.flush     = fl;
`endif
    #1;
    exp_ready = !rst && (m_occ != 2) && !fl;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    if (known) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_occ != 0});
      chk("occ", {30'd0, bus.occ}, m_occ[W-1:0]);
    end
    do_pop = known && !rst && (m_occ != 0) && ordy;
    do_acc = iv && exp_ready;
    if (do_pop) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else                chk("out_data", bus.out_data, sb.pop_front());
    end
    if (rst || fl) begin
      sb.delete();
      m_occ = 0;
      if (rst) known = 1'b1;
    end else begin
      if (do_acc) sb.push_back(id);
      m_occ = m_occ + int'(do_acc) - int'(do_pop);
    end
    @(posedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef MU_SKID_FLUSH_EN
    bus.flush     = 1'b0;
`endif

    // Reset for two cycles with in_valid high
    cycle(1, 0, 1, 32'hDEAD, 0);
    cycle(1, 0, 1, 32'hDEAD, 0);
    @(negedge clk); #1;
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_occ", {30'd0, bus.occ}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    cycle(0, 0, 0, 32'h0, 0);

    // Streaming
    cycle(0, 0, 1, 32'h11, 1);
    cycle(0, 0, 1, 32'h22, 1);
    cycle(0, 0, 1, 32'h33, 1);
    cycle(0, 0, 0, 32'h0,  1);
    cycle(0, 0, 0, 32'h0,  1);

    // Skid fill then drain
    cycle(0, 0, 1, 32'hA0, 0);
    cycle(0, 0, 1, 32'hA1, 0);
    cycle(0, 0, 1, 32'hA2, 0);
    cycle(0, 0, 1, 32'hA2, 1);
    cycle(0, 0, 1, 32'hA2, 1);
    cycle(0, 0, 0, 32'h0,  1);
    cycle(0, 0, 0, 32'h0,  1);

    // Simultaneous accept and pop in BUSY
    cycle(0, 0, 1, 32'hD0, 0);
    cycle(0, 0, 1, 32'hD1, 1);
    cycle(0, 0, 1, 32'hD2, 1);
    cycle(0, 0, 0, 32'h0,  1);

    // Reset while FULL discards both beats
    cycle(0, 0, 1, 32'hB0, 0);
    cycle(0, 0, 1, 32'hB1, 0);
    cycle(1, 0, 0, 32'h0,  0);
    cycle(0, 0, 0, 32'h0,  1);
    cycle(0, 0, 1, 32'hB2, 1);
    cycle(0, 0, 0, 32'h0,  1);

`ifdef MU_SKID_FLUSH_EN
    // Flush while FULL with a beat offered
    cycle(0, 0, 1, 32'hC0, 0);
    cycle(0, 0, 1, 32'hC1, 0);
    cycle(0, 1, 1, 32'hC2, 0);
    cycle(0, 0, 0, 32'h0,  1);
    cycle(0, 0, 1, 32'hC3, 1);
    cycle(0, 0, 0, 32'h0,  1);
`endif

    // Randomised tail for mixed back-pressure
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
